exc_handler: RTL and testbench
==============================

// Module: exc_handler
// PURPOSE
//  Consumer side of the CP0 register file. Takes the MEM-stage instruction's exception flags and CP0 status/cause/epc.
//  Decides whether an exception, interrupt or ERET is taken.
//  Issues the CP0 update command, flushes the pipeline and hands the redirect PC to fetch over a valid/ready handshake.
//  Sits between the MEM stage, CP0_reg and the PC/fetch unit.
// PARAMETERS
//  EXC_VECTOR    32'hBFC00380  target PC for every exception/interrupt
//  FLUSH_CYCLES  2             cycles flush_o is held high (1..15)
// PORTS
//  clk               in   1   clock, rising edge
//  rst               in   1   asynchronous, active-low reset
//  mem_valid_i       in   1   MEM-stage slot holds a real instruction
//  exc_flags_i       in   8   [0]AdEL-fetch [1]RI [2]Ov [3]Syscall [4]Break [5]AdEL-load [6]AdES [7]ERET
//  pc_i              in   32  PC of MEM-stage instruction
//  badaddr_i         in   32  faulting data/fetch address
//  in_delay_slot_i   in   1   MEM-stage instruction is in a branch delay slot
//  status_i          in   32  CP0 Status
//  cause_i           in   32  CP0 Cause
//  epc_i             in   32  CP0 EPC
//  cp0_wen_i         in   1   pending MTC0 in WB stage, not yet written to CP0
//  cp0_waddr_i       in   5   pending MTC0 address (12 Status, 13 Cause, 14 EPC)
//  cp0_wdata_i       in   32  pending MTC0 data
//  redirect_ready_i  in   1   fetch accepts new PC
//  busy_o            out  1   FSM not IDLE; upstream must stall issue
//  flush_o           out  1   kill IF..MEM stage contents
//  redirect_valid_o  out  1   new_pc_o is valid
//  new_pc_o          out  32  redirect target
//  exc_commit_o      out  1   one-cycle pulse: CP0 must record an exception
//  exc_code_o        out  5   Cause.ExcCode to write
//  exc_epc_o         out  32  EPC to write
//  exc_bd_o          out  1   Cause.BD to write
//  epc_we_o          out  1   write EPC/BD (0 when Status.EXL already 1)
//  badv_we_o         out  1   write BadVAddr with exc_badvaddr_o
//  exc_badvaddr_o    out  32  faulting address
//  eret_commit_o     out  1   one-cycle pulse: CP0 clears Status.EXL
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, counter 0; every output 0.
//  Bypass: effective Status/Cause/EPC = cp0_wdata_i when cp0_wen_i and address matches.
//   Cause bypass replaces only bits [9:8].
//  Interrupt pending: |(Cause[15:8] & Status[15:8]), Status.IE[0]=1 and Status.EXL[1]=0.
//   Uses effective values.
//  Detection: combinational, IDLE only, requires mem_valid_i.
//   Priority, first wins: Int(0) > AdEL-fetch(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > AdEL-load(4) > AdES(5) > ERET.
//  EPC value: in_delay_slot_i ? pc_i-4 : pc_i (mod 2^32). BD = in_delay_slot_i.
//  epc_we_o = ~effective Status.EXL.
//  badv_we_o = 1 only for codes 4 and 5. exc_badvaddr_o = pc_i for AdEL-fetch, badaddr_i for load/store.
//  Latency: event detected at edge N.
//   Cycle N+1: registered exc_commit_o or eret_commit_o pulses for exactly one cycle.
//   Cycle N+1: flush_o rises; state enters FLUSH.
//  FSM: IDLE -(event)-> FLUSH -(count==FLUSH_CYCLES-1)-> REDIRECT -(redirect_ready_i)-> IDLE.
//   FLUSH: flush_o=1, counter increments from 0.
//   REDIRECT: redirect_valid_o=1; new_pc_o held stable until the accepting cycle.
//   new_pc_o = EXC_VECTOR for exceptions/interrupts, effective EPC for ERET; latched at detection.
//   Ready may already be high on REDIRECT entry: handshake completes in 1 cycle, IDLE next cycle.
//   busy_o = (state != IDLE).
//  While busy: exc_flags_i, mem_valid_i and interrupts are ignored.
//   Pending interrupts stay level in Cause and are retaken after return to IDLE.
//  mem_valid_i=0 or no flag and no interrupt: no action, outputs stay 0.
//  rst asserted mid-FLUSH/REDIRECT: immediate IDLE, no commit pulse, no redirect.
// TESTING
//  1. Ov flag, pc_i=0x80001000, not BD, EXL=0.
//     -> next cycle commit=1, code=12, epc=0x80001000, epc_we=1.
//     -> flush high 2 cycles, then redirect_valid with new_pc=0xBFC00380.
//  2. Syscall in delay slot, pc_i=0x80000204 -> epc=0x80000200, bd=1, code=8.
//  3. Cause[10]=1, Status=0x0000_0401, RI flag also set -> code=0 (Int) wins, RI dropped.
//     Same case with Status.EXL=1 -> RI taken with epc_we=0.
//  4. ERET, epc_i=0x80000010, pending MTC0 EPC=0x80000020.
//     -> eret_commit pulse, new_pc=0x80000020 (bypass).
//  5. redirect_ready_i low 5 cycles in REDIRECT -> valid held, new_pc stable, busy=1.
//     Flags during busy -> no second commit.
//  6. Drop rst during FLUSH -> all outputs 0 asynchronously.
//     After release + new AdES at 0x1003 -> code=5, badv_we=1, badvaddr=0x1003.

Source files
------------

// File: rtl/exc_handler.sv
// exc_handler: takes exceptions/interrupts/ERET from MEM, commands CP0, flushes and redirects fetch
module exc_handler #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [7:0]  exc_flags_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] badaddr_i,
  input  logic        in_delay_slot_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        cp0_wen_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic        redirect_ready_i,
  output logic        busy_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] new_pc_o,
  output logic        exc_commit_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_epc_o,
  output logic        exc_bd_o,
  output logic        epc_we_o,
  output logic        badv_we_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        eret_commit_o
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] target;
  logic [31:0] eff_status, eff_cause, eff_epc, epc_val, bad_val;
  logic        int_pend, any_exc, ev, bw;
  logic [4:0]  code;
  logic [7:0]  f;
  assign busy_o = state != IDLE;
  assign f = exc_flags_i;
  // Forward an MTC0 still in WB, then pick the highest-priority event for this instruction
  always_comb begin
    eff_status = (cp0_wen_i && cp0_waddr_i == 5'd12) ? cp0_wdata_i : status_i;
    eff_cause  = (cp0_wen_i && cp0_waddr_i == 5'd13) ? {cause_i[31:10], cp0_wdata_i[9:8], cause_i[7:0]} : cause_i;
    eff_epc    = (cp0_wen_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : epc_i;
    int_pend   = (|(eff_cause[15:8] & eff_status[15:8])) & eff_status[0] & ~eff_status[1];
    any_exc    = int_pend | (|f[6:0]);
    ev         = mem_valid_i & (any_exc | f[7]);
    code       = int_pend ? 5'd0 : f[0] ? 5'd4 : f[1] ? 5'd10 : f[2] ? 5'd12 :
                 f[3] ? 5'd8 : f[4] ? 5'd9 : f[5] ? 5'd4 : 5'd5;
    bw         = any_exc & (code == 5'd4 | code == 5'd5);
    bad_val    = (~int_pend & f[0]) ? pc_i : badaddr_i;
    epc_val    = in_delay_slot_i ? pc_i - 32'd4 : pc_i;
  end
  // Control FSM: commit pulse and flush on detection, hold flush, then handshake the redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      target           <= '0;
      flush_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      new_pc_o         <= '0;
      exc_commit_o     <= 1'b0;
      eret_commit_o    <= 1'b0;
      exc_code_o       <= '0;
      exc_epc_o        <= '0;
      exc_bd_o         <= 1'b0;
      epc_we_o         <= 1'b0;
      badv_we_o        <= 1'b0;
      exc_badvaddr_o   <= '0;
    end else begin
      exc_commit_o   <= 1'b0;
      eret_commit_o  <= 1'b0;
      exc_code_o     <= '0;
      exc_epc_o      <= '0;
      exc_bd_o       <= 1'b0;
      epc_we_o       <= 1'b0;
      badv_we_o      <= 1'b0;
      exc_badvaddr_o <= '0;
      case (state)
        IDLE: if (ev) begin
          state          <= FLUSH;
          cnt            <= '0;
          flush_o        <= 1'b1;
          target         <= any_exc ? EXC_VECTOR : eff_epc;
          exc_commit_o   <= any_exc;
          eret_commit_o  <= ~any_exc;
          exc_code_o     <= any_exc ? code : 5'd0;
          exc_epc_o      <= any_exc ? epc_val : 32'd0;
          exc_bd_o       <= any_exc & in_delay_slot_i;
          epc_we_o       <= any_exc & ~eff_status[1];
          badv_we_o      <= bw;
          exc_badvaddr_o <= bw ? bad_val : 32'd0;
        end
        FLUSH: if (cnt == 4'(FLUSH_CYCLES - 1)) begin
          state            <= REDIRECT;
          flush_o          <= 1'b0;
          redirect_valid_o <= 1'b1;
          new_pc_o         <= target;
        end else cnt <= cnt + 4'd1;
        REDIRECT: if (redirect_ready_i) begin
          state            <= IDLE;
          redirect_valid_o <= 1'b0;
          new_pc_o         <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exc_handler.sv
// tb_exc_handler: directed vectors checked against a behavioural model every cycle plus literal expectations
module tb_exc_handler;
  localparam int FC = 2;
  localparam logic [31:0] VEC = 32'hBFC00380;
  logic        clk = 0, rst = 0;
  logic        mem_valid = 0, in_ds = 0, cp0_wen = 0, ready = 1;
  logic [7:0]  flags = 0;
  logic [31:0] pc = 0, badaddr = 0, status = 0, cause = 0, epc = 0, wdata = 0;
  logic [4:0]  waddr = 0;
  logic        busy, flush, rvalid, commit, bd, epc_we, badv_we, eret;
  logic [31:0] new_pc, exc_epc, badv;
  logic [4:0]  code;
  int nvec = 0, nerr = 0;

  exc_handler #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .exc_flags_i(flags), .pc_i(pc),
    .badaddr_i(badaddr), .in_delay_slot_i(in_ds), .status_i(status), .cause_i(cause),
    .epc_i(epc), .cp0_wen_i(cp0_wen), .cp0_waddr_i(waddr), .cp0_wdata_i(wdata),
    .redirect_ready_i(ready), .busy_o(busy), .flush_o(flush), .redirect_valid_o(rvalid),
    .new_pc_o(new_pc), .exc_commit_o(commit), .exc_code_o(code), .exc_epc_o(exc_epc),
    .exc_bd_o(bd), .epc_we_o(epc_we), .badv_we_o(badv_we), .exc_badvaddr_o(badv),
    .eret_commit_o(eret));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected outputs as plain variables
  bit        m_busy, m_redir, m_commit, m_eret, m_bd, m_epcwe, m_bw;
  int        m_flush_left;
  bit [31:0] m_pc, m_target, m_epc, m_bad;
  bit [4:0]  m_code;

  task automatic m_clear_pulses();
    m_commit = 0; m_eret = 0; m_code = 0; m_epc = 0; m_bd = 0; m_epcwe = 0; m_bw = 0; m_bad = 0;
  endtask

  task automatic m_decide();
    bit [31:0] st, ca, ep;
    bit irq;
    int idx;
    int codes[7] = '{4, 10, 12, 8, 9, 4, 5};
    st = (cp0_wen && waddr == 12) ? wdata : status;
    ca = cause;
    if (cp0_wen && waddr == 13) ca[9:8] = wdata[9:8];
    ep = (cp0_wen && waddr == 14) ? wdata : epc;
    irq = ((ca[15:8] & st[15:8]) != 0) && st[0] && !st[1];
    idx = -1;
    for (int i = 6; i >= 0; i--) if (flags[i]) idx = i;
    if (!mem_valid || (!irq && idx < 0 && !flags[7])) return;
    m_busy = 1;
    m_flush_left = FC;
    if (irq || idx >= 0) begin
      m_commit = 1;
      m_code = irq ? 5'd0 : 5'(codes[idx]);
      m_epc = in_ds ? pc - 32'd4 : pc;
      m_bd = in_ds;
      m_epcwe = !st[1];
      m_bw = !irq && (idx == 0 || idx == 5 || idx == 6);
      m_bad = m_bw ? (idx == 0 ? pc : badaddr) : 32'd0;
      m_target = VEC;
    end else begin
      m_eret = 1;
      m_target = ep;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_busy = 0; m_redir = 0; m_flush_left = 0; m_pc = 0; m_target = 0;
      m_clear_pulses();
    end else begin
      m_clear_pulses();
      if (!m_busy) m_decide();
      else if (m_flush_left > 0) begin
        m_flush_left--;
        if (m_flush_left == 0) begin
          m_redir = 1;
          m_pc = m_target;
        end
      end else if (m_redir && ready) begin
        m_redir = 0; m_busy = 0; m_pc = 0;
      end
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    cmp("busy", 32'(busy), 32'(m_busy));
    cmp("flush", 32'(flush), 32'(m_flush_left > 0));
    cmp("redirect_valid", 32'(rvalid), 32'(m_redir));
    cmp("new_pc", new_pc, m_pc);
    cmp("exc_commit", 32'(commit), 32'(m_commit));
    cmp("eret_commit", 32'(eret), 32'(m_eret));
    cmp("exc_code", 32'(code), 32'(m_code));
    cmp("exc_epc", exc_epc, m_epc);
    cmp("exc_bd", 32'(bd), 32'(m_bd));
    cmp("epc_we", 32'(epc_we), 32'(m_epcwe));
    cmp("badv_we", 32'(badv_we), 32'(m_bw));
    cmp("badvaddr", badv, m_bad);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_in();
    mem_valid = 0; flags = 0; in_ds = 0; cp0_wen = 0; waddr = 0; wdata = 0;
  endtask

  task automatic fire(input logic [7:0] fl, input logic [31:0] p);
    mem_valid = 1; flags = fl; pc = p;
    step();
    clear_in();
    #3;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    cmp("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #3 cmp("reset_busy", 32'(busy), 32'd0);
    cmp("reset_newpc", new_pc, 32'd0);
    step(); step();
    rst = 1;
    // flags with no valid slot: nothing happens
    flags = 8'h04; pc = 32'h80000000;
    step(); clear_in(); #3;
    cmp("novalid_commit", 32'(commit), 32'd0);
    cmp("novalid_busy", 32'(busy), 32'd0);
    // 1: overflow, full sequence
    step();
    fire(8'h04, 32'h80001000);
    cmp("t1_commit", 32'(commit), 32'd1);
    cmp("t1_code", 32'(code), 32'd12);
    cmp("t1_epc", exc_epc, 32'h80001000);
    cmp("t1_epcwe", 32'(epc_we), 32'd1);
    cmp("t1_flush0", 32'(flush), 32'd1);
    step(); #3;
    cmp("t1_flush1", 32'(flush), 32'd1);
    cmp("t1_commit_once", 32'(commit), 32'd0);
    step(); #3;
    cmp("t1_rvalid", 32'(rvalid), 32'd1);
    cmp("t1_newpc", new_pc, 32'hBFC00380);
    cmp("t1_flush_off", 32'(flush), 32'd0);
    step(); #3;
    cmp("t1_idle", 32'(busy), 32'd0);
    // 2: syscall in delay slot
    step();
    in_ds = 1;
    fire(8'h08, 32'h80000204);
    cmp("t2_code", 32'(code), 32'd8);
    cmp("t2_epc", exc_epc, 32'h80000200);
    cmp("t2_bd", 32'(bd), 32'd1);
    wait_idle();
    // 3a: interrupt beats RI
    step();
    cause = 32'h400; status = 32'h401;
    fire(8'h02, 32'h80000300);
    cmp("t3_code_int", 32'(code), 32'd0);
    cmp("t3_commit", 32'(commit), 32'd1);
    cmp("t3_epcwe", 32'(epc_we), 32'd1);
    wait_idle();
    // 3b: EXL masks the interrupt, RI taken without EPC write
    step();
    status = 32'h403;
    fire(8'h02, 32'h80000300);
    cmp("t3b_code", 32'(code), 32'd10);
    cmp("t3b_epcwe", 32'(epc_we), 32'd0);
    wait_idle();
    cause = 0; status = 0;
    // AdEL-fetch beats AdEL-load, BadVAddr from PC
    step();
    badaddr = 32'h12345678;
    fire(8'h21, 32'h80000401);
    cmp("fetch_code", 32'(code), 32'd4);
    cmp("fetch_bw", 32'(badv_we), 32'd1);
    cmp("fetch_bad", badv, 32'h80000401);
    wait_idle();
    // 4: ERET with pending MTC0 EPC
    step();
    epc = 32'h80000010; cp0_wen = 1; waddr = 5'd14; wdata = 32'h80000020;
    fire(8'h80, 32'h80000500);
    cmp("t4_eret", 32'(eret), 32'd1);
    cmp("t4_nocommit", 32'(commit), 32'd0);
    step(); step(); #3;
    cmp("t4_rvalid", 32'(rvalid), 32'd1);
    cmp("t4_newpc", new_pc, 32'h80000020);
    wait_idle();
    // 5: stalled redirect, flags during busy ignored
    step();
    ready = 0;
    fire(8'h04, 32'h80000600);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      mem_valid = 1; flags = 8'h08;
      #3;
      cmp("t5_rvalid", 32'(rvalid), 32'd1);
      cmp("t5_newpc", new_pc, 32'hBFC00380);
      cmp("t5_busy", 32'(busy), 32'd1);
      cmp("t5_nocommit", 32'(commit), 32'd0);
      step();
    end
    clear_in(); ready = 1;
    wait_idle();
    // 6: reset during flush, then AdES
    step();
    fire(8'h04, 32'h80000700);
    step();
    #1 rst = 0;
    #1;
    cmp("t6_flush", 32'(flush), 32'd0);
    cmp("t6_busy", 32'(busy), 32'd0);
    cmp("t6_commit", 32'(commit), 32'd0);
    cmp("t6_rvalid", 32'(rvalid), 32'd0);
    step(); step();
    rst = 1;
    step();
    badaddr = 32'h1003;
    fire(8'h40, 32'h80000800);
    cmp("t6_code", 32'(code), 32'd5);
    cmp("t6_bw", 32'(badv_we), 32'd1);
    cmp("t6_bad", badv, 32'h1003);
    wait_idle();
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
